// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard controller states and opcode classification helpers.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // True when the instruction reads its rt field as a source operand.
    function automatic logic usesRt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that needs the result of the load currently in EX.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic [31:0] instr_out_1,
    input  logic        dREN_out_2,
    input  logic [4:0]  rt_out_2,
    output logic        lu
);

    logic [5:0] w_opcode;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_rsHit;
    logic       w_rtHit;

    assign w_opcode = instr_out_1[31:26];
    assign w_rs     = instr_out_1[25:21];
    assign w_rt     = instr_out_1[20:16];

    assign w_rsHit = (rt_out_2 == w_rs);
    assign w_rtHit = usesRt(w_opcode) && (rt_out_2 == w_rt);

    // A load into $0 never produces a value worth waiting for.
    assign lu = dREN_out_2 && (rt_out_2 != 5'd0) && (w_rsHit || w_rtHit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: bar enables, flushes, PC write,
// halt tracking, stall statistics and a data-memory watchdog.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WAIT_MAX = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] instr_out_1,
    input  logic        dREN_out_2,
    input  logic [4:0]  rt_out_2,
    input  logic        dREN_out_3,
    input  logic        dWEN_out_3,
    input  logic        xfer_3,
    input  logic        halt_or_out_4,
    output logic        pc_en,
    output logic        en_1,
    output logic        en_2,
    output logic        en_3,
    output logic        en_4,
    output logic        flush_1,
    output logic        flush_2,
    output logic        flush_3,
    output logic        flush_4,
    output logic        halted,
    output logic        wd_err,
    output logic [31:0] stall_cnt
);

    hazard_state_t r_state;
    hazard_state_t w_nextState;
    logic          r_halted;
    logic          r_wdErr;
    logic [31:0]   r_stallCnt;
    logic [31:0]   r_waitCnt;
    logic          w_lu;
    logic          w_memWait;
    logic          w_pcEn;
    logic [3:0]    w_en;
    logic [3:0]    w_flush;

    load_use_detect u_loadUse (
        .instr_out_1 (instr_out_1),
        .dREN_out_2  (dREN_out_2),
        .rt_out_2    (rt_out_2),
        .lu          (w_lu)
    );

    // While waiting, the MEM bar is frozen, so only dhit decides whether the wait ends.
    always_comb begin
        w_memWait = 1'b0;
        case (r_state)
            RUN:      w_memWait = (dREN_out_3 || dWEN_out_3) && !dhit;
            MEM_WAIT: w_memWait = !dhit;
            default:  w_memWait = 1'b0;
        endcase
    end

    always_comb begin
        w_pcEn      = 1'b1;
        w_en        = 4'b1111;
        w_flush     = 4'b0000;
        w_nextState = r_state;
        if (RST) begin
            w_pcEn      = 1'b0;
            w_flush     = 4'b1111;
            w_nextState = RUN;
        end else if (r_state == HALT) begin
            w_pcEn      = 1'b0;
            w_en        = 4'b0000;
            w_nextState = HALT;
        end else begin
            w_nextState = RUN;
            if (w_memWait) begin
                w_pcEn      = 1'b0;
                w_en        = 4'b1000;
                w_flush     = 4'b1000;
                w_nextState = MEM_WAIT;
            end else if (xfer_3) begin
                w_flush = 4'b0111;
            end else if (w_lu) begin
                w_pcEn  = 1'b0;
                w_en    = 4'b1110;
                w_flush = 4'b0010;
            end else if (!ihit) begin
                w_pcEn  = 1'b0;
                w_flush = 4'b0001;
            end
            if (halt_or_out_4) begin
                w_nextState = HALT;
            end
        end
    end

    // Statistics and the watchdog are frozen once the pipeline has halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= RUN;
            r_halted   <= 1'b0;
            r_wdErr    <= 1'b0;
            r_stallCnt <= 32'd0;
            r_waitCnt  <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (halt_or_out_4) begin
                r_halted <= 1'b1;
            end
            if ((r_state != HALT) && !w_pcEn && (r_stallCnt != 32'hFFFF_FFFF)) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
            if (w_memWait) begin
                if (r_waitCnt != 32'hFFFF_FFFF) begin
                    r_waitCnt <= r_waitCnt + 32'd1;
                end
                if ((r_waitCnt + 32'd1) >= 32'(WAIT_MAX)) begin
                    r_wdErr <= 1'b1;
                end
            end else begin
                r_waitCnt <= 32'd0;
            end
        end
    end

    assign pc_en     = w_pcEn;
    assign en_1      = w_en[0];
    assign en_2      = w_en[1];
    assign en_3      = w_en[2];
    assign en_4      = w_en[3];
    assign flush_1   = w_flush[0];
    assign flush_2   = w_flush[1];
    assign flush_3   = w_flush[2];
    assign flush_4   = w_flush[3];
    assign halted    = r_halted;
    assign wd_err    = r_wdErr;
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each step pushes its expected outputs,
// then pops and compares them against the DUT between clock edges.
module tb_hazard_ctrl;

    localparam int WAIT_MAX = 64;

    localparam logic [31:0] I_ADD_RS5 = 32'h00A21820;
    localparam logic [31:0] I_ADD_RT5 = 32'h00451820;
    localparam logic [31:0] I_ADDI    = 32'h20450007;
    localparam logic [31:0] I_ADD_R0  = 32'h00021820;
    localparam logic [31:0] I_SW      = 32'hAC450000;

    typedef struct {
        logic        pc;
        logic [3:0]  en;
        logic [3:0]  fl;
        logic        halted;
        logic        wd;
        logic [31:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ihit;
    logic        dhit;
    logic [31:0] instr;
    logic        dren2;
    logic [4:0]  rt2;
    logic        dren3;
    logic        dwen3;
    logic        xfer;
    logic        haltIn;
    logic        pc_en;
    logic        en_1, en_2, en_3, en_4;
    logic        flush_1, flush_2, flush_3, flush_4;
    logic        halted;
    logic        wd_err;
    logic [31:0] stall_cnt;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expStall = 32'd0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK           (clk),
        .RST           (rst),
        .ihit          (ihit),
        .dhit          (dhit),
        .instr_out_1   (instr),
        .dREN_out_2    (dren2),
        .rt_out_2      (rt2),
        .dREN_out_3    (dren3),
        .dWEN_out_3    (dwen3),
        .xfer_3        (xfer),
        .halt_or_out_4 (haltIn),
        .pc_en         (pc_en),
        .en_1          (en_1),
        .en_2          (en_2),
        .en_3          (en_3),
        .en_4          (en_4),
        .flush_1       (flush_1),
        .flush_2       (flush_2),
        .flush_3       (flush_3),
        .flush_4       (flush_4),
        .halted        (halted),
        .wd_err        (wd_err),
        .stall_cnt     (stall_cnt)
    );

    // Returns every input to an idle, free-running pipeline.
    task automatic idleInputs();
        rst    = 1'b0;
        ihit   = 1'b1;
        dhit   = 1'b1;
        instr  = 32'd0;
        dren2  = 1'b0;
        rt2    = 5'd0;
        dren3  = 1'b0;
        dwen3  = 1'b0;
        xfer   = 1'b0;
        haltIn = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        logic [3:0] obsEn;
        logic [3:0] obsFl;
        e     = sb.pop_front();
        obsEn = {en_4, en_3, en_2, en_1};
        obsFl = {flush_4, flush_3, flush_2, flush_1};
        checks++;
        assert (pc_en === e.pc) else begin
            errors++;
            $error("FAIL %s pc_en observed %0b expected %0b", tag, pc_en, e.pc);
        end
        checks++;
        assert (obsEn === e.en) else begin
            errors++;
            $error("FAIL %s en[4:1] observed %b expected %b", tag, obsEn, e.en);
        end
        checks++;
        assert (obsFl === e.fl) else begin
            errors++;
            $error("FAIL %s flush[4:1] observed %b expected %b", tag, obsFl, e.fl);
        end
        checks++;
        assert (halted === e.halted) else begin
            errors++;
            $error("FAIL %s halted observed %0b expected %0b", tag, halted, e.halted);
        end
        checks++;
        assert (wd_err === e.wd) else begin
            errors++;
            $error("FAIL %s wd_err observed %0b expected %0b", tag, wd_err, e.wd);
        end
        checks++;
        assert (stall_cnt === e.stall) else begin
            errors++;
            $error("FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, e.stall);
        end
    endtask

    // Inputs are already driven; expected halted/wd_err describe the registered
    // state left by the previous edge, the rest describe this cycle's decision.
    task automatic applyStimulus(input string tag, input logic pc, input logic [3:0] en,
                                 input logic [3:0] fl, input logic expHalted,
                                 input logic expWd);
        exp_t e;
        e.pc     = pc;
        e.en     = en;
        e.fl     = fl;
        e.halted = expHalted;
        e.wd     = expWd;
        e.stall  = expStall;
        sb.push_back(e);
        #1;
        checkOutput(tag);
        if (rst) begin
            expStall = 32'd0;
        end else if (!expHalted && !pc) begin
            expStall = expStall + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        @(negedge clk);

        rst = 1'b1;
        applyStimulus("reset", 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);

        idleInputs(); instr = I_ADD_RS5; rt2 = 5'd5;
        applyStimulus("run_noload", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        dren2 = 1'b1;
        applyStimulus("lu_rs", 1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0);

        dren2 = 1'b0;
        applyStimulus("lu_bubble", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        idleInputs(); instr = I_ADD_RT5; dren2 = 1'b1; rt2 = 5'd5;
        applyStimulus("lu_rt", 1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0);

        instr = I_ADDI;
        applyStimulus("addi_norut", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        instr = I_ADD_R0; rt2 = 5'd0;
        applyStimulus("load_r0", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        instr = I_SW; rt2 = 5'd5;
        applyStimulus("lu_sw", 1'b0, 4'b1110, 4'b0010, 1'b0, 1'b0);

        idleInputs(); ihit = 1'b0;
        applyStimulus("imiss", 1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0);

        idleInputs(); xfer = 1'b1; instr = I_ADD_RS5; dren2 = 1'b1; rt2 = 5'd5;
        applyStimulus("xfer_lu", 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b0);

        idleInputs(); dren3 = 1'b1; dhit = 1'b0; xfer = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus("dmem_wait", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
        end
        dhit = 1'b1;
        applyStimulus("dmem_hit_xfer", 1'b1, 4'b1111, 4'b0111, 1'b0, 1'b0);

        idleInputs(); dwen3 = 1'b1; dhit = 1'b0;
        applyStimulus("store_wait", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
        dhit = 1'b1;
        applyStimulus("store_hit", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        idleInputs();
        applyStimulus("idle", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        dren3 = 1'b1; dhit = 1'b0;
        for (int k = 0; k < WAIT_MAX; k++) begin
            applyStimulus("wd_wait", 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
        end
        dhit = 1'b1;
        applyStimulus("wd_hit", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
        idleInputs();
        applyStimulus("wd_sticky", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);

        rst = 1'b1;
        applyStimulus("wd_reset", 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1);
        idleInputs();
        applyStimulus("wd_cleared", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        haltIn = 1'b1;
        applyStimulus("halt_req", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
        idleInputs(); ihit = 1'b0; xfer = 1'b1;
        applyStimulus("halted_1", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        ihit = 1'b1; dren3 = 1'b1; dhit = 1'b0;
        applyStimulus("halted_2", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        idleInputs(); rst = 1'b1; haltIn = 1'b1;
        applyStimulus("halt_reset", 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
        idleInputs();
        applyStimulus("after_halt", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/flush controller for the 5-stage pipeline. It drives the per-bar enable and flush controls that the four pipeline register bars (IF/ID, ID/EX, EX/MEM, MEM/WB) consume, plus the PC write enable. Its inputs are the bar outputs and the cache hit signals. It resolves load-use hazards, taken control transfers, instruction and data memory waits, and halt, and it keeps stall statistics and a data-memory watchdog.

## Interface
Parameters:
- WAIT_MAX, 64: dMEM wait cycles allowed before `wd_err` is set.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- instr_out_1  in  32  instruction currently in ID.
- dREN_out_2  in  1  EX-stage instruction is a load.
- rt_out_2  in  5  destination of the EX-stage load.
- dREN_out_3, dWEN_out_3  in  1 each  MEM-stage memory request.
- xfer_3  in  1  taken control transfer resolved in MEM (beq&zero | bne&~zero | j | JR | jal).
- halt_or_out_4  in  1  halt reached WB.
- pc_en  out  1  PC loads its next value.
- en_1..en_4  out  1 each  bar N captures its inputs.
- flush_1..flush_4  out  1 each  bar N captures a bubble (all control bits 0); only meaningful when en_N=1.
- halted  out  1  sticky halt.
- wd_err  out  1  sticky watchdog error.
- stall_cnt  out  32  cycles with pc_en=0 since reset, excluding HALT.

## Operation
- States: RUN, MEM_WAIT, HALT; encoded as hazard_state_t.
- Load-use (`lu`): dREN_out_2 & rt_out_2!=0 & (rt_out_2==ID rs | (ID uses rt & rt_out_2==ID rt)). ID uses rt for R-type, beq, bne, sw.
- Priority within RUN, highest first:
  1. dmem pending, i.e. (dREN_out_3|dWEN_out_3)&~dhit: go to MEM_WAIT. pc_en=0, en_1..en_3=0, en_4=1, flush_4=1.
  2. xfer_3: pc_en=1; all en=1; flush_1, flush_2, flush_3=1 (squash IF, ID, EX).
  3. lu: pc_en=0, en_1=0, en_2=1, flush_2=1; en_3 and en_4=1.
  4. ~ihit: pc_en=0, en_1=1, flush_1=1; other bars advance.
  5. Otherwise all en=1, no flush, pc_en=1.
- MEM_WAIT: outputs are the same as rule 1 while ~dhit. On dhit, outputs follow the RUN priority chain evaluated combinationally with the pending term false, and the state returns to RUN.
- Watchdog: a wait counter increments each MEM_WAIT cycle and clears on leaving MEM_WAIT. When the count reaches WAIT_MAX, wd_err sets; operation continues.
- halt_or_out_4=1 in any state goes to HALT. HALT is held until RST. In HALT: all en=0, pc_en=0, halted=1.

## Timing
- State, halted, wd_err, stall_cnt and the wait counter are registered. All enables and flushes are combinational from the current state and inputs, so they take effect at the next CLK edge.
- Load-use inserts exactly one bubble. The next cycle EX holds that bubble, so lu=0.
- A taken transfer costs 3 squashed slots and is applied in the same cycle xfer_3 is seen, unless a dmem wait is pending. In that case it is applied in the dhit cycle.
- During the RST cycle: pc_en=0, all en=1, all flush=1. After RST: state=RUN, halted=0, wd_err=0, stall_cnt=0, wait counter=0.
- RST asserted mid-MEM_WAIT or in HALT returns to RUN on the next edge. RST has priority over halt.
- stall_cnt saturates at 32'hFFFFFFFF.

## Structure
- Add hazard_state_t to cpu_types_pkg, along with an opcode-class helper for "uses rt" if one is not already present.
- Sub-module: load_use_detect, combinational. Inputs are instr_out_1, dREN_out_2 and rt_out_2; output is lu.
- The controller outputs connect directly to the bar enable/flush inputs; the existing dhit/flush pins are fed from en_N/flush_N.

## Test plan
- Load-use: EX lw with rt=5; ID `add $3,$5,$2` -> one cycle with pc_en=0, en_1=0, flush_2=1. The next cycle has all en=1.
- Load to $0, or an ID instruction that does not use rt (addi rt=5) -> no stall.
- dREN_out_3=1 with dhit low for 3 cycles -> 3 cycles of MEM_WAIT, en_1..en_3=0, flush_4=1, stall_cnt=+3. The dhit cycle advances all bars.
- xfer_3=1 simultaneously with lu -> flush_1..flush_3=1, pc_en=1, no lu stall.
- dhit held low for WAIT_MAX=64 cycles -> wd_err=1 on cycle 64 and stays 1; RST clears it.
- halt_or_out_4=1 -> halted=1 on the next edge, all en=0 thereafter; ihit/xfer_3 ignored until RST.
